// File: rtl/wb_b3_pkg.sv
// rtl/wb_b3_pkg.sv - Wishbone B3 cycle-type/burst-type enums and burst address helper
package wb_b3_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_t;

    // Wrapping bursts only advance the word bits inside their aligned block.
    function automatic logic [31:0] wb_next_adr(logic [31:0] adr, bte_t bte);
        logic [31:0] nxt;
        nxt = adr;
        unique case (bte)
            LINEAR: nxt      = adr + 32'd4;
            WRAP4:  nxt[3:2] = adr[3:2] + 2'd1;
            WRAP8:  nxt[4:2] = adr[4:2] + 3'd1;
            WRAP16: nxt[5:2] = adr[5:2] + 4'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sram_sp_be.sv
// rtl/sram_sp_be.sv - single-port synchronous RAM, 32-bit words with 4 byte enables
module sram_sp_be #(
    parameter int    DEPTH    = 1024,
    parameter string MEM_FILE = ""
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] adr_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              dat_i,
    output logic [31:0]              dat_o
);

    logic [31:0] mem_q [DEPTH];

    // Read returns the pre-write contents when reading the word being written.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) mem_q[adr_i][8*b +: 8] <= dat_i[8*b +: 8];
        end
        dat_o <= mem_q[adr_i];
    end

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone B3 SRAM slave, classic + registered incrementing bursts
// Define WB_SRAM_RANGE_ERR_EN to answer out-of-range addresses with wbs_err_o.
module wb_sram_slave
    import wb_b3_pkg::*;
#(
    parameter int    MEM_SIZE_BYTES = 4096,
    parameter int    ADDR_WIDTH     = 32,
    parameter string MEM_FILE       = ""
) (
    input  logic                  clk,
    input  logic                  rst_sys_n,
    input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [2:0]            wbs_cti_i,
    input  logic [1:0]            wbs_bte_i,
    output logic                  wbs_ack_o,
    output logic                  wbs_err_o,
    output logic                  wbs_rty_o,
    output logic [31:0]           wbs_dat_o
);

    localparam int MEM_AW = $clog2(MEM_SIZE_BYTES);
    localparam int DEPTH  = MEM_SIZE_BYTES / 4;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST} state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d, adr_nxt;
    logic [MEM_AW-3:0]     ram_idx;
    logic [31:0]           ram_rdata;
    logic                  req, adr_ok, beat_cont, oor_in, oor_nxt;

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign beat_cont = (wbs_cti_i == INCR);
    assign adr_nxt   = ADDR_WIDTH'(wb_next_adr(32'(adr_q), bte_t'(wbs_bte_i)));
    // A burst beat is only acknowledged when the master is at the predicted address.
    assign adr_ok    = (state_q != BURST) || (wbs_adr_i[ADDR_WIDTH-1:2] == adr_q[ADDR_WIDTH-1:2]);
    assign wbs_ack_o = ack_q & req & adr_ok;
    assign wbs_rty_o = 1'b0;
    assign wbs_dat_o = wbs_ack_o ? ram_rdata : 32'h0;

`ifdef WB_SRAM_RANGE_ERR_EN
    assign oor_in    = |wbs_adr_i[ADDR_WIDTH-1:MEM_AW];
    assign oor_nxt   = |adr_nxt[ADDR_WIDTH-1:MEM_AW];
    assign wbs_err_o = err_q & req;
`else
    assign oor_in    = 1'b0;
    assign oor_nxt   = 1'b0;
    assign wbs_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        adr_d   = adr_q;
        ram_idx = adr_q[MEM_AW-1:2];
        if (!wbs_cyc_i) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ram_idx = wbs_adr_i[MEM_AW-1:2];
                    if (wbs_stb_i) begin
                        adr_d   = wbs_adr_i;
                        ack_d   = !oor_in;
                        err_d   = oor_in;
                        state_d = (beat_cont && !oor_in) ? BURST : SINGLE;
                    end
                end
                SINGLE: begin
                    if (wbs_stb_i && (ack_q || err_q)) begin
                        state_d = IDLE;
                        ack_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                BURST: begin
                    if (wbs_stb_i) begin
                        if (err_q) begin
                            state_d = IDLE;
                            err_d   = 1'b0;
                        end else if (!adr_ok) begin
                            ram_idx = wbs_adr_i[MEM_AW-1:2];
                            adr_d   = wbs_adr_i;
                            ack_d   = !oor_in;
                            err_d   = oor_in;
                        end else if (beat_cont) begin
                            // Writes need the port for the current beat; reads prefetch the next.
                            ram_idx = wbs_we_i ? adr_q[MEM_AW-1:2] : adr_nxt[MEM_AW-1:2];
                            adr_d   = adr_nxt;
                            ack_d   = !oor_nxt;
                            err_d   = oor_nxt;
                        end else begin
                            state_d = IDLE;
                            ack_d   = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
        end
    end

    sram_sp_be #(
        .DEPTH    (DEPTH),
        .MEM_FILE (MEM_FILE)
    ) u_ram (
        .clk_i (clk),
        .adr_i (ram_idx),
        .we_i  (wbs_ack_o & wbs_we_i),
        .be_i  (wbs_sel_i),
        .dat_i (wbs_dat_i),
        .dat_o (ram_rdata)
    );

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - directed and random Wishbone traffic against a word-array reference model
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;
    logic [31:0] dat_o;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [31:0] ref_mem [1024];

    always #5 clk = ~clk;

    wb_sram_slave dut (
        .clk       (clk),
        .rst_sys_n (rst_n),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_sel_i (sel),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_cti_i (cti),
        .wbs_bte_i (bte),
        .wbs_ack_o (ack),
        .wbs_err_o (err),
        .wbs_rty_o (rty),
        .wbs_dat_o (dat_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return ref_mem[(a >> 2) % 1024];
    endfunction

    task automatic mwr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[(a >> 2) % 1024][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] b);
        logic [31:0] blk;
        if (b == 2'd0) return a + 32'd4;
        blk = 32'd8 << b;
        return (a / blk) * blk + ((a % blk) + 32'd4) % blk;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    endtask

    task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input string tag, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; cti = 3'b000; bte = 2'b00;
        @(negedge clk); chk({tag, " lat"}, ack, 0);
        tick();
        @(negedge clk);
        chk({tag, " ack"}, ack, 1);
        chk({tag, " err"}, err, 0);
        rd = dat_o;
        if (w) mwr(a, d, s);
        else chk({tag, " dat"}, dat_o, mrd(a));
        tick();
        drop();
        @(negedge clk); chk({tag, " idle"}, ack, 0);
        tick();
    endtask

    task automatic burst(input logic w, input logic [31:0] a0, input logic [1:0] b,
                         input int n, input string tag);
        logic [31:0] a, d;
        a = a0;
        cyc = 1'b1; stb = 1'b1; we = w; bte = b; sel = 4'hf;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            adr = a; dat = d; cti = (i == n - 1) ? 3'b111 : 3'b010;
            if (i == 0) begin
                @(negedge clk); chk({tag, " lat"}, ack, 0);
                tick();
            end
            @(negedge clk);
            chk({tag, " ack"}, ack, 1);
            if (w) mwr(a, d, 4'hf);
            else chk({tag, " dat"}, dat_o, mrd(a));
            tick();
            a = nxt(a, b);
        end
        drop();
        @(negedge clk); chk({tag, " end"}, ack, 0);
        tick();
    endtask

    initial begin
        logic [31:0] rd, d, v20, a;
        int          n;
        logic [1:0]  b;
        logic        w;

        rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; dat = 32'h0;
        sel = 4'h0; cti = 3'b000; bte = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ack", ack, 0);
        chk("reset err", err, 0);
        chk("reset rty", rty, 0);
        chk("reset dat", dat_o, 32'h0);
        tick();
        drop();
        rst_n = 1'b1;
        tick();

        burst(1'b1, 32'h0, 2'd0, 1024, "fill");

        single(1'b1, 32'h100, 32'hDEADBEEF, 4'hf, "t1 wr", rd);
        single(1'b0, 32'h100, 32'h0, 4'hf, "t1 rd", rd);
        chk("t1 value", rd, 32'hDEADBEEF);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h100; cti = 3'b000;
        @(negedge clk); chk("t1 b2b lat", ack, 0);
        tick(); @(negedge clk); chk("t1 b2b ack1", ack, 1);
        tick(); @(negedge clk); chk("t1 b2b wait", ack, 0);
        tick(); @(negedge clk); chk("t1 b2b ack2", ack, 1); chk("t1 b2b dat", dat_o, 32'hDEADBEEF);
        tick(); drop(); tick();

        single(1'b1, 32'h20, 32'h11223344, 4'hf, "t2 wr", rd);
        single(1'b1, 32'h20, 32'h0000AA00, 4'b0010, "t2 byte", rd);
        single(1'b0, 32'h20, 32'h0, 4'hf, "t2 rd", rd);
        chk("t2 value", rd, 32'h1122AA44);

        burst(1'b0, 32'h40, 2'd0, 4, "t3 lin");

        v20 = mrd(32'h20);
        burst(1'b1, 32'h18, 2'd1, 4, "t4 wrap wr");
        single(1'b0, 32'h20, 32'h0, 4'hf, "t4 untouched", rd);
        chk("t4 0x20 value", rd, v20);
        burst(1'b0, 32'h18, 2'd1, 4, "t4 wrap rd");

        cyc = 1'b1; stb = 1'b1; we = 1'b0; bte = 2'b00; sel = 4'hf; adr = 32'h80; cti = 3'b010;
        @(negedge clk); chk("t5 lat", ack, 0);
        tick(); @(negedge clk); chk("t5 b0 ack", ack, 1); chk("t5 b0 dat", dat_o, mrd(32'h80));
        tick(); stb = 1'b0; adr = 32'h84;
        @(negedge clk); chk("t5 ws1", ack, 0);
        tick(); @(negedge clk); chk("t5 ws2", ack, 0);
        tick(); stb = 1'b1;
        @(negedge clk); chk("t5 b1 ack", ack, 1); chk("t5 b1 dat", dat_o, mrd(32'h84));
        tick(); adr = 32'h200;
        @(negedge clk); chk("t5 mismatch wait", ack, 0);
        tick(); @(negedge clk); chk("t5 mis ack", ack, 1); chk("t5 mis dat", dat_o, mrd(32'h200));
        tick(); adr = 32'h204; cti = 3'b111;
        @(negedge clk); chk("t5 last ack", ack, 1); chk("t5 last dat", dat_o, mrd(32'h204));
        tick(); drop();
        @(negedge clk); chk("t5 end", ack, 0);
        tick();

        d = $urandom;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h300; dat = d; sel = 4'hf; cti = 3'b010;
        @(negedge clk); chk("t5w lat", ack, 0);
        tick(); @(negedge clk); chk("t5w b0 ack", ack, 1); mwr(32'h300, d, 4'hf);
        tick(); stb = 1'b0; adr = 32'h304; dat = ~d;
        @(negedge clk); chk("t5w ws1", ack, 0);
        tick(); @(negedge clk); chk("t5w ws2", ack, 0);
        tick(); stb = 1'b1; cti = 3'b111; d = $urandom; dat = d; sel = 4'b0001;
        @(negedge clk); chk("t5w b1 ack", ack, 1); mwr(32'h304, d, 4'b0001);
        tick(); drop(); tick();
        single(1'b0, 32'h300, 32'h0, 4'hf, "t5w rd0", rd);
        single(1'b0, 32'h304, 32'h0, 4'hf, "t5w rd1", rd);

        cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = 2'b00; sel = 4'hf; cti = 3'b010;
        for (int i = 0; i < 2; i++) begin
            d = $urandom; adr = 32'h400 + 32'(4 * i); dat = d;
            if (i == 0) begin
                @(negedge clk); chk("t6 lat", ack, 0);
                tick();
            end
            @(negedge clk); chk("t6 beat ack", ack, 1); mwr(adr, d, 4'hf);
            tick();
        end
        cyc = 1'b0; adr = 32'h408; dat = $urandom;
        @(negedge clk); chk("t6 cyc drop", ack, 0);
        tick(); drop(); tick();
        for (int i = 0; i < 4; i++) single(1'b0, 32'h400 + 32'(4 * i), 32'h0, 4'hf, "t6 rd", rd);

        d = $urandom;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h500; dat = d; cti = 3'b010;
        @(negedge clk); chk("t6r lat", ack, 0);
        tick(); @(negedge clk); chk("t6r b0 ack", ack, 1); mwr(32'h500, d, 4'hf);
        tick(); adr = 32'h504; dat = $urandom; rst_n = 1'b0;
        @(negedge clk); chk("t6r rst ack", ack, 0); chk("t6r rst dat", dat_o, 32'h0);
        tick(); drop(); rst_n = 1'b1; tick();
        single(1'b0, 32'h500, 32'h0, 4'hf, "t6r rd0", rd);
        single(1'b0, 32'h504, 32'h0, 4'hf, "t6r rd1", rd);

`ifdef WB_SRAM_RANGE_ERR_EN
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h2000; cti = 3'b000;
        @(negedge clk); chk("rng lat err", err, 0); chk("rng lat ack", ack, 0);
        tick(); @(negedge clk);
        chk("rng err", err, 1); chk("rng ack", ack, 0); chk("rng dat", dat_o, 32'h0);
        tick(); drop();
        @(negedge clk); chk("rng end", err, 0);
        tick();
`else
        single(1'b1, 32'h1044, $urandom, 4'hf, "alias wr", rd);
        single(1'b0, 32'h44, 32'h0, 4'hf, "alias rd", rd);
`endif

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(1, 8);
            b = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 1015)) * 32'd4;
            if (k % 3 == 0) single(w, a, $urandom, 4'($urandom_range(1, 15)), "rnd single", rd);
            else burst(w, a, b, n, "rnd burst");
        end
        for (int i = 0; i < 64; i += 8) burst(1'b0, 32'(i * 4), 2'd0, 8, "final rd");
        chk("rty tied", rty, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
